freq_div_prog: RTL and testbench
================================

Name: freq_div_prog

Overview:
Runtime-programmable clock divider. It generates a 50%-duty divided clock or a one-cycle tick from the global clock. The divisor is loaded through a shadow register and takes effect only at a terminal count, so the output never glitches. It sits between the board clock and the slow-rate logic (display scan, counters, debouncers), replacing the fixed-constant dividers.

Parameters:
CNT_W, 27, width of the half-period counter and of the divisor.
DEFAULT_DIV, 50000000, divisor loaded at reset. Half-period is DEFAULT_DIV+1 cycles. Must fit in CNT_W bits.

Ports:
clk  input  1  global clock; all logic on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  count enable; when low, counter and outputs hold.
clr  input  1  synchronous clear of counter and outputs.
mode  input  1  0 = toggle (divided clock), 1 = pulse (one-cycle high per terminal count).
div_val  input  CNT_W  new divisor value.
div_load  input  1  one-cycle strobe; captures div_val into the shadow register.
clk_out  output  1  divided clock (mode 0) or pulse (mode 1), registered.
tick  output  1  one-cycle high at every terminal count, registered, either mode.
div_ack  output  1  one-cycle high when the shadow divisor is applied.
pend  output  1  high while a loaded divisor is waiting to be applied.

Behaviour:
- Reset (rst_n low, asynchronous):
  - cnt=0, clk_out=0, tick=0, div_ack=0, pend=0.
  - div_active=DEFAULT_DIV, div_shadow=DEFAULT_DIV.
- Terminal count (TC) = en & (cnt >= div_active). The >= comparison is the guard against an out-of-range cnt.
- Priority each edge, highest first: clr, then en=0, then TC, then increment.
- clr=1:
  - cnt<=0, clk_out<=0, tick<=0, div_ack<=0.
  - div_shadow and pend are preserved; a pending load still applies at the next TC.
- en=0 (clr=0): cnt, clk_out and div_active hold; tick<=0, div_ack<=0.
- TC:
  - cnt<=0, tick<=1.
  - mode 0: clk_out<=~clk_out.
  - mode 1: clk_out<=1.
  - If pend=1: div_active<=div_shadow, pend<=0, div_ack<=1.
- en=1, no TC:
  - cnt<=cnt+1 (CNT_W-bit, wraps).
  - tick<=0, div_ack<=0.
  - mode 1: clk_out<=0. mode 0: clk_out holds.
- Timing:
  - Half-period = div_active+1 clk cycles.
  - Mode 0 output period = 2*(div_active+1) cycles.
  - Mode 1 pulse period = div_active+1 cycles.
- div_val=0: TC on every enabled cycle. Mode 0 gives clk/2; tick and mode-1 clk_out stay continuously high.
- div_load=1:
  - div_shadow<=div_val, pend<=1.
  - A repeated load while pend=1 overwrites the shadow; last write wins, and only one div_ack is produced.
- div_load on the same edge as TC:
  - The TC applies the shadow value held before that edge.
  - The new value lands in the shadow with pend=1 and applies at the following TC.
  - When pend was 0 before that edge, div_active is unchanged at this TC.
- Mode switch:
  - Sampled every edge.
  - 0->1: clk_out drops to 0 on the next non-TC enabled edge.
  - 1->0: clk_out holds its current level until the next TC toggles it.
- Latency: clk_out, tick and div_ack are all registered and change on the TC edge itself; there is no combinational path from inputs to outputs.
- Reset asserted mid-count or mid-pending: everything returns to the reset values and the pending load is discarded.

Decomposition:
- Shared package freq_div_pkg holds:
  - CNT_W default (27) and DEFAULT_DIV (50000000).
  - Mode encodings MODE_TOGGLE=1'b0, MODE_PULSE=1'b1.
  - Bench constants: 1 Hz and 100 Hz divisor values for the 100 MHz board clock.
- No sub-module; counter, shadow register and output logic fit in one module. Multi-rate designs instantiate it several times.

Test Plan:
- Reset and default, CNT_W=8, DEFAULT_DIV=3, en=1, mode 0 -> clk_out toggles every 4 cycles, period 8; tick high one cycle every 4 cycles; first TC on the 4th edge after rst_n rises.
- Runtime load: div_val=1 strobed mid-count with cnt=1 -> pend=1; at the next TC, div_ack=1 and pend=0; from then on tick comes every 2 cycles and clk_out period is 4.
- Double load plus coincident TC: load 5, then load 2 on the exact TC edge -> that TC applies 5; at the next TC, 2 applies with exactly one div_ack per application; pend is high between them.
- Pulse mode and div_val=0: mode=1, div=3 -> clk_out is one-cycle high every 4 cycles, identical to tick. Load 0 -> after the applying TC, tick stays continuously high.
- Enable/clear: deassert en for 10 cycles at cnt=2 -> cnt and clk_out frozen, tick=0; resume -> TC after 2 more cycles. Assert clr with pend=1 -> cnt=0, clk_out=0, pend stays 1 and applies at the next TC.
- Async reset mid-operation: drop rst_n between edges while pend=1 and clk_out=1 -> all outputs go to 0 immediately without a clock edge; after release, the DEFAULT_DIV timing from the first scenario repeats.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared constants for the programmable frequency divider and the logic that uses it.
// Divisor values assume the 100 MHz board clock and a toggle-mode (50% duty) output.
package freq_div_pkg;

  localparam int FD_CNT_W       = 27;
  localparam int FD_DEFAULT_DIV = 50000000;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Half-period is div+1 cycles, so a full toggle period is 2*(div+1) cycles.
  localparam logic [FD_CNT_W-1:0] DIV_1HZ   = FD_CNT_W'(49999999);
  localparam logic [FD_CNT_W-1:0] DIV_100HZ = FD_CNT_W'(499999);

endpackage

// File: rtl/freq_div_prog.sv
// Runtime-programmable clock divider: 50% divided clock or one-cycle pulse per terminal count.
// New divisors wait in a shadow register and are applied only at a terminal count.
module freq_div_prog
  import freq_div_pkg::*;
#(
  parameter int CNT_W       = FD_CNT_W,
  parameter int DEFAULT_DIV = FD_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             mode,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_ack,
  output logic             pend
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_active;
  logic [CNT_W-1:0] div_shadow;
  logic             tc;
  logic             pulse;

  // >= rather than == so a counter left above a freshly shrunk divisor still terminates.
  assign tc    = en & (cnt >= div_active);
  assign pulse = (mode == MODE_PULSE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      div_ack    <= 1'b0;
      pend       <= 1'b0;
      div_active <= DIV_RST;
      div_shadow <= DIV_RST;
    end else begin
      if (clr) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        div_ack <= 1'b0;
      end else if (!en) begin
        tick    <= 1'b0;
        div_ack <= 1'b0;
      end else if (tc) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= pulse ? 1'b1 : ~clk_out;
        if (pend) begin
          div_active <= div_shadow;
          pend       <= 1'b0;
          div_ack    <= 1'b1;
        end else begin
          div_ack <= 1'b0;
        end
      end else begin
        cnt     <= cnt + CNT_W'(1);
        tick    <= 1'b0;
        div_ack <= 1'b0;
        if (pulse) clk_out <= 1'b0;
      end

      // Placed last so a load coinciding with an applying TC leaves pend set for the new value.
      if (div_load) begin
        div_shadow <= div_val;
        pend       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_div_prog.sv
// Scoreboard bench for freq_div_prog with CNT_W=8, DEFAULT_DIV=3.
// Expected ticks (edge number, clk_out, div_ack, pend) are queued by the stimulus and popped by the monitor.
module tb_freq_div_prog;
  import freq_div_pkg::*;

  localparam int W = 8;

  typedef struct {
    int   at_edge;
    logic clk_out;
    logic ack;
    logic pend;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic         mode;
  logic [W-1:0] div_val;
  logic         div_load;
  logic         clk_out;
  logic         tick;
  logic         div_ack;
  logic         pend;

  exp_t exp_q[$];
  int   edge_cnt  = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;
  bit   pulse_chk = 0;
  int   base;

  freq_div_prog #(.CNT_W(W), .DEFAULT_DIV(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .mode     (mode),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_ack  (div_ack),
    .pend     (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [W-1:0] val, input logic md,
                               input logic e, input logic c);
    div_load = ld;
    div_val  = val;
    mode     = md;
    en       = e;
    clr      = c;
  endtask

  task automatic pushExpected(input int at_edge, input logic c, input logic a, input logic p);
    exp_t x;
    x.at_edge = at_edge;
    x.clk_out = c;
    x.ack     = a;
    x.pend    = p;
    exp_q.push_back(x);
  endtask

  // Monitor: every tick must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      if (tick) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_tick", 32'(edge_cnt), 32'hFFFF_FFFF);
        end else begin
          x = exp_q.pop_front();
          checkOutput("tick_edge", 32'(edge_cnt), 32'(x.at_edge));
          checkOutput("tick_clk_out", 32'(clk_out), 32'(x.clk_out));
          checkOutput("tick_div_ack", 32'(div_ack), 32'(x.ack));
          checkOutput("tick_pend", 32'(pend), 32'(x.pend));
        end
      end else if (div_ack) begin
        checkOutput("ack_without_tick", 32'(div_ack), 32'd0);
      end
      if (pulse_chk) checkOutput("pulse_eq_tick", 32'(clk_out), 32'(tick));
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, MODE_TOGGLE, 1'b1, 1'b0);

    // Reset state and default divisor timing
    repeat (3) @(negedge clk);
    checkOutput("rst_clk_out", 32'(clk_out), 32'd0);
    checkOutput("rst_tick", 32'(tick), 32'd0);
    checkOutput("rst_div_ack", 32'(div_ack), 32'd0);
    checkOutput("rst_pend", 32'(pend), 32'd0);
    rst_n = 1'b1;
    base  = edge_cnt;
    pushExpected(base + 4,  1'b1, 1'b0, 1'b0);
    pushExpected(base + 8,  1'b0, 1'b0, 1'b0);
    pushExpected(base + 12, 1'b1, 1'b0, 1'b0);
    pushExpected(base + 16, 1'b0, 1'b0, 1'b0);
    repeat (16) @(negedge clk);

    // Runtime load of 1 while cnt=1
    $display("[TB] runtime load");
    base = edge_cnt;
    pushExpected(base + 4,  1'b1, 1'b1, 1'b0);
    pushExpected(base + 6,  1'b0, 1'b0, 1'b0);
    pushExpected(base + 8,  1'b1, 1'b0, 1'b0);
    pushExpected(base + 10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'd1, MODE_TOGGLE, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, MODE_TOGGLE, 1'b1, 1'b0);
    checkOutput("load_pend", 32'(pend), 32'd1);
    repeat (8) @(negedge clk);

    // Load 5, then load 2 on the TC that applies 5
    $display("[TB] double load");
    base = edge_cnt;
    pushExpected(base + 2,  1'b1, 1'b1, 1'b1);
    pushExpected(base + 8,  1'b0, 1'b1, 1'b0);
    pushExpected(base + 11, 1'b1, 1'b0, 1'b0);
    pushExpected(base + 14, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd5, MODE_TOGGLE, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'd2, MODE_TOGGLE, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, MODE_TOGGLE, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("dbl_pend_between", 32'(pend), 32'd1);
    repeat (9) @(negedge clk);

    // Pulse mode with div 3, then div 0
    $display("[TB] pulse mode");
    base = edge_cnt;
    pushExpected(base + 3,  1'b1, 1'b1, 1'b0);
    pushExpected(base + 7,  1'b1, 1'b0, 1'b0);
    pushExpected(base + 11, 1'b1, 1'b0, 1'b0);
    pushExpected(base + 15, 1'b1, 1'b1, 1'b0);
    for (int i = 16; i <= 23; i++) pushExpected(base + i, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd3, MODE_PULSE, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, MODE_PULSE, 1'b1, 1'b0);
    pulse_chk = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(1'b1, 8'd0, MODE_PULSE, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, MODE_PULSE, 1'b1, 1'b0);
    repeat (11) @(negedge clk);

    // Enable freeze and clear with a pending load
    $display("[TB] enable and clear");
    pulse_chk = 1'b0;
    base = edge_cnt;
    pushExpected(base + 1,  1'b0, 1'b0, 1'b1);
    pushExpected(base + 2,  1'b1, 1'b1, 1'b0);
    pushExpected(base + 6,  1'b0, 1'b0, 1'b0);
    pushExpected(base + 10, 1'b1, 1'b0, 1'b0);
    pushExpected(base + 24, 1'b0, 1'b0, 1'b0);
    pushExpected(base + 28, 1'b1, 1'b0, 1'b0);
    pushExpected(base + 34, 1'b1, 1'b1, 1'b0);
    pushExpected(base + 36, 1'b0, 1'b0, 1'b0);
    pushExpected(base + 38, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd3, MODE_TOGGLE, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, MODE_TOGGLE, 1'b1, 1'b0);
    repeat (11) @(negedge clk);
    applyStimulus(1'b0, 8'd0, MODE_TOGGLE, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("freeze_clk_out_mid", 32'(clk_out), 32'd1);
    checkOutput("freeze_tick_mid", 32'(tick), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("freeze_clk_out_end", 32'(clk_out), 32'd1);
    checkOutput("freeze_tick_end", 32'(tick), 32'd0);
    applyStimulus(1'b0, 8'd0, MODE_TOGGLE, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    applyStimulus(1'b1, 8'd1, MODE_TOGGLE, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, MODE_TOGGLE, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, MODE_TOGGLE, 1'b1, 1'b0);
    checkOutput("clr_clk_out", 32'(clk_out), 32'd0);
    checkOutput("clr_pend_kept", 32'(pend), 32'd1);
    repeat (8) @(negedge clk);

    // Async reset while a load is pending and clk_out is high
    $display("[TB] async reset");
    applyStimulus(1'b1, 8'd7, MODE_TOGGLE, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, MODE_TOGGLE, 1'b1, 1'b0);
    checkOutput("pre_rst_pend", 32'(pend), 32'd1);
    checkOutput("pre_rst_clk_out", 32'(clk_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clk_out", 32'(clk_out), 32'd0);
    checkOutput("async_tick", 32'(tick), 32'd0);
    checkOutput("async_div_ack", 32'(div_ack), 32'd0);
    checkOutput("async_pend", 32'(pend), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base  = edge_cnt;
    pushExpected(base + 4,  1'b1, 1'b0, 1'b0);
    pushExpected(base + 8,  1'b0, 1'b0, 1'b0);
    pushExpected(base + 12, 1'b1, 1'b0, 1'b0);
    pushExpected(base + 16, 1'b0, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    applyStimulus(1'b0, 8'd0, MODE_TOGGLE, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    while (exp_q.size() != 0) begin
      checkOutput("missing_tick", 32'(exp_q[0].at_edge), 32'hFFFF_FFFF);
      void'(exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
